// File: rtl/ili9341_spi_cmd_decoder.sv
// ili9341_spi_cmd_decoder
//   Display-side decoder for the ILI9341 4-wire SPI link. It synchronises
//   SCK/CS_n/DC/MOSI into clk, rebuilds bytes, and tracks the
//   CASET/PASET/RAMWR/SLPOUT/DISPON/MADCTL/COLMOD state. During RAMWR it
//   emits RGB565 pixels together with their x/y addresses.
// Ports
//   clk, rst                 system clock (>= 4x sclk), async active-high reset
//   sclk, cs_n, dc, mosi     raw SPI pins (mode 0, MSB first)
//   byte_valid/byte_data/byte_is_cmd   received byte strobe and payload
//   col_start/col_end/page_start/page_end   committed address window
//   sleep_out, disp_on, madctl, colmod      panel mode state
//   pixel_valid/pixel_data/pixel_x/pixel_y  decoded RGB565 pixel stream
//   unknown_cmd              pulse on an undecoded command byte
// Optional feature macro: ILI_DEC_STATS_EN adds cmd_count, pixel_count and
//   frame_done; without it those ports and counters are absent.
module ili9341_spi_cmd_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] COL_RST     = 16'h00EF,
  parameter logic [15:0] PAGE_RST    = 16'h013F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        dc,
  input  logic        mosi,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_cmd,
  output logic [15:0] col_start,
  output logic [15:0] col_end,
  output logic [15:0] page_start,
  output logic [15:0] page_end,
  output logic        sleep_out,
  output logic        disp_on,
  output logic [7:0]  madctl,
  output logic [7:0]  colmod,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        unknown_cmd
`ifdef ILI_DEC_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [31:0] pixel_count,
  output logic        frame_done
`endif
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CASET, ST_PASET, ST_MADCTL, ST_COLMOD, ST_RAMWR, ST_SKIP
  } state_t;

  // Pin synchronisers; cs_n resets to the deselected level.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, dc_sync, mosi_sync;
  logic                   sclk_q;
  logic                   sclk_s, cs_s, dc_s, mosi_s, sclk_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;

  // Byte assembly; deselect discards any partially shifted byte.
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_is_cmd <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[BYTE_W-3:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
          byte_valid  <= 1'b1;
          byte_data   <= {shift_q, mosi_s};
          byte_is_cmd <= ~dc_s;
        end
      end
    end
  end

  // Command decoder state and its next-state values.
  state_t             state, state_d;
  logic [1:0]         param_idx, param_idx_d;
  logic [COORD_W-1:0] sh_start, sh_start_d;
  logic [BYTE_W-1:0]  sh_end_hi, sh_end_hi_d;
  logic               hi_flag, hi_flag_d;
  logic [BYTE_W-1:0]  hi_byte, hi_byte_d;
  logic [COORD_W-1:0] x_cnt, x_cnt_d, y_cnt, y_cnt_d;
  logic [COORD_W-1:0] col_start_d, col_end_d, page_start_d, page_end_d;
  logic               sleep_out_d, disp_on_d;
  logic [BYTE_W-1:0]  madctl_d, colmod_d;
  logic               pixel_valid_d, unknown_cmd_d;
  logic [COORD_W-1:0] pixel_data_d, pixel_x_d, pixel_y_d;
`ifdef ILI_DEC_STATS_EN
  logic               frame_wrap_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      param_idx   <= '0;
      sh_start    <= '0;
      sh_end_hi   <= '0;
      hi_flag     <= 1'b0;
      hi_byte     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      col_start   <= '0;
      col_end     <= COL_RST;
      page_start  <= '0;
      page_end    <= PAGE_RST;
      sleep_out   <= 1'b0;
      disp_on     <= 1'b0;
      madctl      <= '0;
      colmod      <= 8'h66;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      unknown_cmd <= 1'b0;
    end else begin
      state       <= state_d;
      param_idx   <= param_idx_d;
      sh_start    <= sh_start_d;
      sh_end_hi   <= sh_end_hi_d;
      hi_flag     <= hi_flag_d;
      hi_byte     <= hi_byte_d;
      x_cnt       <= x_cnt_d;
      y_cnt       <= y_cnt_d;
      col_start   <= col_start_d;
      col_end     <= col_end_d;
      page_start  <= page_start_d;
      page_end    <= page_end_d;
      sleep_out   <= sleep_out_d;
      disp_on     <= disp_on_d;
      madctl      <= madctl_d;
      colmod      <= colmod_d;
      pixel_valid <= pixel_valid_d;
      pixel_data  <= pixel_data_d;
      pixel_x     <= pixel_x_d;
      pixel_y     <= pixel_y_d;
      unknown_cmd <= unknown_cmd_d;
    end
  end

  always_comb begin
    state_d       = state;
    param_idx_d   = param_idx;
    sh_start_d    = sh_start;
    sh_end_hi_d   = sh_end_hi;
    hi_flag_d     = hi_flag;
    hi_byte_d     = hi_byte;
    x_cnt_d       = x_cnt;
    y_cnt_d       = y_cnt;
    col_start_d   = col_start;
    col_end_d     = col_end;
    page_start_d  = page_start;
    page_end_d    = page_end;
    sleep_out_d   = sleep_out;
    disp_on_d     = disp_on;
    madctl_d      = madctl;
    colmod_d      = colmod;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data;
    pixel_x_d     = pixel_x;
    pixel_y_d     = pixel_y;
    unknown_cmd_d = 1'b0;
`ifdef ILI_DEC_STATS_EN
    frame_wrap_d  = 1'b0;
`endif

    // Deselect drops a half-received pixel but keeps the decoder state.
    if (cs_s) hi_flag_d = 1'b0;

    if (byte_valid && byte_is_cmd) begin
      param_idx_d = '0;
      hi_flag_d   = 1'b0;
      case (byte_data)
        8'h2A: state_d = ST_CASET;
        8'h2B: state_d = ST_PASET;
        8'h36: state_d = ST_MADCTL;
        8'h3A: state_d = ST_COLMOD;
        8'h2C: begin
          state_d = ST_RAMWR;
          x_cnt_d = col_start;
          y_cnt_d = page_start;
        end
        8'h11: begin sleep_out_d = 1'b1; state_d = ST_IDLE; end
        8'h10: begin sleep_out_d = 1'b0; state_d = ST_IDLE; end
        8'h29: begin disp_on_d   = 1'b1; state_d = ST_IDLE; end
        8'h28: begin disp_on_d   = 1'b0; state_d = ST_IDLE; end
        8'h00: state_d = ST_IDLE;
        default: begin
          state_d       = ST_SKIP;
          unknown_cmd_d = 1'b1;
        end
      endcase
    end else if (byte_valid) begin
      case (state)
        ST_CASET, ST_PASET: begin
          param_idx_d = param_idx + 2'd1;
          case (param_idx)
            2'd0: sh_start_d[15:8] = byte_data;
            2'd1: sh_start_d[7:0]  = byte_data;
            2'd2: sh_end_hi_d      = byte_data;
            default: begin
              // Window commits only once all four parameters arrived.
              if (state == ST_CASET) begin
                col_start_d = sh_start;
                col_end_d   = {sh_end_hi, byte_data};
              end else begin
                page_start_d = sh_start;
                page_end_d   = {sh_end_hi, byte_data};
              end
              state_d = ST_SKIP;
            end
          endcase
        end
        ST_MADCTL: begin madctl_d = byte_data; state_d = ST_SKIP; end
        ST_COLMOD: begin colmod_d = byte_data; state_d = ST_SKIP; end
        ST_RAMWR: begin
          if (!hi_flag) begin
            hi_byte_d = byte_data;
            hi_flag_d = 1'b1;
          end else begin
            hi_flag_d     = 1'b0;
            pixel_valid_d = 1'b1;
            pixel_data_d  = {hi_byte, byte_data};
            pixel_x_d     = x_cnt;
            pixel_y_d     = y_cnt;
            // Only equality ends a row; start > end rolls through 16'hFFFF.
            if (x_cnt == col_end) begin
              x_cnt_d = col_start;
              if (y_cnt == page_end) begin
                y_cnt_d = page_start;
`ifdef ILI_DEC_STATS_EN
                frame_wrap_d = 1'b1;
`endif
              end else begin
                y_cnt_d = y_cnt + COORD_W'(1);
              end
            end else begin
              x_cnt_d = x_cnt + COORD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ILI_DEC_STATS_EN
  // Saturating link statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count   <= '0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_wrap_d;
      if (byte_valid && byte_is_cmd && (cmd_count != 16'hFFFF))
        cmd_count <= cmd_count + 16'd1;
      if (pixel_valid_d && (pixel_count != 32'hFFFF_FFFF))
        pixel_count <= pixel_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ili9341_spi_cmd_decoder.sv
// Directed testbench for ili9341_spi_cmd_decoder: drives SPI bytes at
// clk/8 and checks byte, state and pixel outputs against constants.
module tb_ili9341_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs_n, dc, mosi;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_cmd;
  logic [15:0] col_start, col_end, page_start, page_end;
  logic        sleep_out, disp_on;
  logic [7:0]  madctl, colmod;
  logic        pixel_valid;
  logic [15:0] pixel_data, pixel_x, pixel_y;
  logic        unknown_cmd;
`ifdef ILI_DEC_STATS_EN
  logic [15:0] cmd_count;
  logic [31:0] pixel_count;
  logic        frame_done;
`endif

  int checks = 0;
  int errors = 0;

  ili9341_spi_cmd_decoder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .dc(dc), .mosi(mosi),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_cmd(byte_is_cmd),
    .col_start(col_start), .col_end(col_end),
    .page_start(page_start), .page_end(page_end),
    .sleep_out(sleep_out), .disp_on(disp_on), .madctl(madctl), .colmod(colmod),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .unknown_cmd(unknown_cmd)
`ifdef ILI_DEC_STATS_EN
    , .cmd_count(cmd_count), .pixel_count(pixel_count), .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: logs bytes ({is_data, byte}), unknown commands, pixels.
  logic [8:0]  byte_log [$];
  logic [7:0]  unk_log  [$];
  logic [15:0] px_log [$];
  logic [15:0] py_log [$];
  logic [15:0] pd_log [$];
  logic [7:0]  last_cmd = 8'h00;
  int          unk_pulses = 0;

  always @(negedge clk) begin
    if (byte_valid) begin
      byte_log.push_back({~byte_is_cmd, byte_data});
      if (byte_is_cmd) last_cmd = byte_data;
    end
    if (unknown_cmd) begin
      unk_log.push_back(last_cmd);
      unk_pulses++;
    end
    if (pixel_valid) begin
      px_log.push_back(pixel_x);
      py_log.push_back(pixel_y);
      pd_log.push_back(pixel_data);
    end
  end

  task automatic spi_send(input logic is_data, input logic [7:0] b, input int nbits);
    cs_n = 1'b0;
    dc   = is_data;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    spi_send(1'b0, b, 8);
  endtask

  task automatic dat(input logic [7:0] b);
    spi_send(1'b1, b, 8);
  endtask

  task automatic test_reset;
    checks++; if (col_end !== 16'h00EF) begin errors++; $display("FAIL reset_col_end got %h want 00ef", col_end); end
    checks++; if (page_end !== 16'h013F) begin errors++; $display("FAIL reset_page_end got %h want 013f", page_end); end
    checks++; if (colmod !== 8'h66) begin errors++; $display("FAIL reset_colmod got %h want 66", colmod); end
    checks++; if ({col_start, page_start, madctl, sleep_out, disp_on} !== 42'd0) begin
      errors++; $display("FAIL reset_zero_state got %h %h %h %b %b want 0", col_start, page_start, madctl, sleep_out, disp_on);
    end
    checks++; if ({byte_valid, pixel_valid, unknown_cmd} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {byte_valid, pixel_valid, unknown_cmd});
    end
  endtask

  task automatic test_init;
    logic [8:0] init_q [$];
    logic [7:0] exp_unk [12];
    int start_b, start_u, bad;
    init_q = '{9'h0CB, 9'h139, 9'h12C, 9'h100, 9'h134, 9'h102,
               9'h0CF, 9'h100, 9'h1C1, 9'h130,
               9'h0E8, 9'h185, 9'h100, 9'h178,
               9'h0EA, 9'h100, 9'h100,
               9'h0ED, 9'h164, 9'h103, 9'h112, 9'h181,
               9'h0F7, 9'h120,
               9'h0C0, 9'h123,
               9'h0C1, 9'h110,
               9'h0C5, 9'h13E, 9'h128,
               9'h0C7, 9'h186,
               9'h036, 9'h148,
               9'h03A, 9'h155,
               9'h0B1, 9'h100, 9'h118,
               9'h0B6, 9'h108, 9'h182, 9'h127,
               9'h011, 9'h029, 9'h02C};
    exp_unk = '{8'hCB, 8'hCF, 8'hE8, 8'hEA, 8'hED, 8'hF7,
                8'hC0, 8'hC1, 8'hC5, 8'hC7, 8'hB1, 8'hB6};
    start_b = byte_log.size();
    start_u = unk_log.size();
    foreach (init_q[k]) spi_send(init_q[k][8], init_q[k][7:0], 8);
    checks++; if (byte_log.size() - start_b != init_q.size()) begin
      errors++; $display("FAIL init_byte_count got %0d want %0d", byte_log.size() - start_b, init_q.size());
    end
    bad = 0;
    foreach (init_q[k]) begin
      if (start_b + k >= byte_log.size() || byte_log[start_b + k] !== init_q[k]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_byte_values got %0d wrong bytes want 0", bad); end
    checks++; if (madctl !== 8'h48) begin errors++; $display("FAIL init_madctl got %h want 48", madctl); end
    checks++; if (colmod !== 8'h55) begin errors++; $display("FAIL init_colmod got %h want 55", colmod); end
    checks++; if (sleep_out !== 1'b1) begin errors++; $display("FAIL init_sleep_out got %b want 1", sleep_out); end
    checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL init_disp_on got %b want 1", disp_on); end
    checks++; if (unk_log.size() - start_u != 12) begin
      errors++; $display("FAIL init_unknown_count got %0d want 12", unk_log.size() - start_u);
    end else begin
      bad = 0;
      for (int k = 0; k < 12; k++) if (unk_log[start_u + k] !== exp_unk[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL init_unknown_codes got %0d wrong want 0", bad); end
    end
  endtask

  task automatic test_pixels;
    logic [15:0] ex [5];
    logic [15:0] ey [5];
    logic [15:0] ed [5];
    int start_p;
    ex = '{16'd10, 16'd11, 16'd10, 16'd11, 16'd10};
    ey = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd5};
    ed = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h1234};
    cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0B);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    checks++; if ({col_start, col_end} !== {16'h000A, 16'h000B}) begin
      errors++; $display("FAIL caset_commit got %h %h want 000a 000b", col_start, col_end);
    end
    checks++; if ({page_start, page_end} !== {16'h0005, 16'h0006}) begin
      errors++; $display("FAIL paset_commit got %h %h want 0005 0006", page_start, page_end);
    end
    start_p = pd_log.size();
    cmd(8'h2C);
    for (int k = 0; k < 5; k++) begin
      dat(ed[k][15:8]);
      dat(ed[k][7:0]);
    end
    checks++; if (pd_log.size() - start_p != 5) begin
      errors++; $display("FAIL ramwr_pixel_count got %0d want 5", pd_log.size() - start_p);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if ({px_log[start_p+k], py_log[start_p+k], pd_log[start_p+k]} !== {ex[k], ey[k], ed[k]}) begin
          errors++;
          $display("FAIL ramwr_pixel%0d got (%0d,%0d) %h want (%0d,%0d) %h", k,
                   px_log[start_p+k], py_log[start_p+k], pd_log[start_p+k], ex[k], ey[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_partial_caset;
    cmd(8'h2A); dat(8'h00); dat(8'h01);
    cmd(8'h2B);
    checks++; if ({col_start, col_end} !== {16'h000A, 16'h000B}) begin
      errors++; $display("FAIL partial_caset got %h %h want 000a 000b", col_start, col_end);
    end
  endtask

  task automatic test_back_to_back;
    int start_p;
    // Half pixel followed by a fresh RAMWR: the stale high byte is dropped.
    start_p = pd_log.size();
    cmd(8'h2C); dat(8'hAB);
    cmd(8'h2C); dat(8'h12); dat(8'h34);
    checks++; if (pd_log.size() - start_p != 1) begin
      errors++; $display("FAIL ramwr_restart_count got %0d want 1", pd_log.size() - start_p);
    end else begin
      checks++;
      if ({px_log[start_p], py_log[start_p], pd_log[start_p]} !== {16'd10, 16'd5, 16'h1234}) begin
        errors++; $display("FAIL ramwr_restart_pixel got (%0d,%0d) %h want (10,5) 1234",
                           px_log[start_p], py_log[start_p], pd_log[start_p]);
      end
    end
    // NOP leaves RAMWR: following data bytes must not form pixels.
    start_p = pd_log.size();
    cmd(8'h00); dat(8'h55); dat(8'h66);
    checks++; if (pd_log.size() != start_p) begin
      errors++; $display("FAIL nop_ends_ramwr got %0d pixels want 0", pd_log.size() - start_p);
    end
    cmd(8'h10);
    checks++; if (sleep_out !== 1'b0) begin errors++; $display("FAIL sleep_in got %b want 0", sleep_out); end
  endtask

  task automatic test_cs_abort;
    int start_b;
    cmd(8'h28);
    checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL disp_off got %b want 0", disp_on); end
    start_b = byte_log.size();
    spi_send(1'b0, 8'hA5, 4);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    cmd(8'h29);
    checks++; if (byte_log.size() - start_b != 1) begin
      errors++; $display("FAIL cs_abort_byte_count got %0d want 1", byte_log.size() - start_b);
    end else begin
      checks++; if (byte_log[start_b] !== 9'h029) begin
        errors++; $display("FAIL cs_abort_byte got %h want 029", byte_log[start_b]);
      end
    end
    checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL cs_abort_disp_on got %b want 1", disp_on); end
  endtask

  task automatic test_reset_mid_ramwr;
    int start_p;
    cmd(8'h2C); dat(8'h55);
    rst = 1'b1;
    #1;
    checks++; if ({col_start, col_end, page_start, page_end} !== {16'h0000, 16'h00EF, 16'h0000, 16'h013F}) begin
      errors++; $display("FAIL rst_window got %h %h %h %h want 0000 00ef 0000 013f",
                         col_start, col_end, page_start, page_end);
    end
    checks++; if ({madctl, colmod, sleep_out, disp_on} !== {8'h00, 8'h66, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mode got %h %h %b %b want 00 66 0 0", madctl, colmod, sleep_out, disp_on);
    end
    checks++; if ({pixel_x, pixel_y, pixel_data} !== 48'd0) begin
      errors++; $display("FAIL rst_pixel_regs got %h %h %h want 0", pixel_x, pixel_y, pixel_data);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    start_p = pd_log.size();
    dat(8'h01); dat(8'h02); dat(8'h03); dat(8'h04);
    checks++; if (pd_log.size() != start_p) begin
      errors++; $display("FAIL rst_idle_data got %0d pixels want 0", pd_log.size() - start_p);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    dc   = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_init;
    test_pixels;
    test_partial_caset;
    test_back_to_back;
    test_cs_abort;
    test_reset_mid_ramwr;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
